// File: rtl/bound_flasher_ctrl.sv
// Control FSM for the bound flasher. It issues the per-cycle count command that walks
// the downstream lamp counter through 0->16->5->11->0->6->0, with flick-driven kickback.
module bound_flasher_ctrl #(
  parameter int CNT_W   = 5,
  parameter int TOP1    = 16,
  parameter int FLOOR1  = 5,
  parameter int TOP2    = 11,
  parameter int TOP3    = 6,
  parameter int KICK_LO = 6,
  parameter int KICK_HI = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             flick,
  input  logic             stop,
  input  logic [CNT_W-1:0] counter,
  output logic [1:0]       counter_state,
  output logic [CNT_W-1:0] counter_load,
  output logic             counter_load_en,
  output logic [2:0]       phase,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, UP1, DN1, UP2, DN2, UP3, DN3, KB} state_t;
  typedef enum logic [1:0] {CNT_DIS, CNT_UP, CNT_DOWN, CNT_HOLD} cmd_t;

  localparam logic [CNT_W-1:0] TOP1_V    = CNT_W'(TOP1);
  localparam logic [CNT_W-1:0] FLOOR1_V  = CNT_W'(FLOOR1);
  localparam logic [CNT_W-1:0] TOP2_V    = CNT_W'(TOP2);
  localparam logic [CNT_W-1:0] TOP3_V    = CNT_W'(TOP3);
  localparam logic [CNT_W-1:0] KICK_LO_V = CNT_W'(KICK_LO);
  localparam logic [CNT_W-1:0] KICK_HI_V = CNT_W'(KICK_HI);

  state_t           state, state_nxt;
  state_t           kb_ret, kb_ret_nxt;
  cmd_t             cmd;
  logic             kick;
  logic [CNT_W-1:0] kb_floor;

  // The command acts on the counter at the same edge the state moves, so every
  // boundary decision is made on the value the counter holds right now.
  always_comb begin
    state_nxt       = state;
    kb_ret_nxt      = kb_ret;
    cmd             = CNT_DIS;
    counter_load_en = 1'b0;
    kick            = flick && (counter == KICK_LO_V || counter == KICK_HI_V);
    kb_floor        = (kb_ret == UP1) ? '0 : FLOOR1_V;

    if (!rst_n) begin
      cmd = CNT_DIS;
    end else if (stop) begin
      counter_load_en = 1'b1;
      state_nxt       = IDLE;
    end else if (!tick) begin
      cmd = (state == IDLE) ? CNT_DIS : CNT_HOLD;
    end else begin
      case (state)
        IDLE: if (flick) begin cmd = CNT_UP; state_nxt = UP1; end
        UP1: begin
          if (kick) begin
            cmd = CNT_DOWN; kb_ret_nxt = UP1; state_nxt = KB;
          end else if (counter == TOP1_V) begin
            cmd = CNT_DOWN; state_nxt = DN1;
          end else cmd = CNT_UP;
        end
        DN1: if (counter == FLOOR1_V) begin cmd = CNT_UP; state_nxt = UP2; end
             else cmd = CNT_DOWN;
        UP2: begin
          if (kick) begin
            cmd = CNT_DOWN; kb_ret_nxt = UP2; state_nxt = KB;
          end else if (counter == TOP2_V) begin
            cmd = CNT_DOWN; state_nxt = DN2;
          end else cmd = CNT_UP;
        end
        DN2: if (counter == '0) begin cmd = CNT_UP; state_nxt = UP3; end
             else cmd = CNT_DOWN;
        UP3: if (counter == TOP3_V) begin cmd = CNT_DOWN; state_nxt = DN3; end
             else cmd = CNT_UP;
        DN3: if (counter == '0) begin cmd = CNT_DIS; state_nxt = IDLE; end
             else cmd = CNT_DOWN;
        KB:  if (counter == kb_floor) begin cmd = CNT_UP; state_nxt = kb_ret; end
             else cmd = CNT_DOWN;
        default: begin cmd = CNT_DIS; state_nxt = IDLE; end
      endcase
    end

    // Last line of defence against wrapping the counter past either end.
    if ((cmd == CNT_UP && counter == TOP1_V) || (cmd == CNT_DOWN && counter == '0))
      cmd = CNT_DIS;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      kb_ret <= UP1;
    end else begin
      state  <= state_nxt;
      kb_ret <= kb_ret_nxt;
    end
  end

  assign counter_state = cmd;
  assign counter_load  = '0;
  assign phase         = state;
  assign busy          = rst_n && (state != IDLE);

endmodule
